// File: rtl/wfm_loader_if.sv
// -----------------------------------------------------------------------------
// wfm_loader_if
// Valid/ready sample stream feeding the waveform table loader.
//   s_data   sample word (OW bits)
//   s_valid  source has a sample on s_data
//   s_last   current sample is the final one of the waveform period
//   s_ready  loader will consume the sample this cycle
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface wfm_loader_if #(
   parameter int OW = 24
) ();

   logic [OW-1:0] s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;

   modport master (
      output s_data,
      output s_valid,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_data,
      input  s_valid,
      input  s_last,
      output s_ready
   );

endinterface : wfm_loader_if

// File: rtl/wfm_loader.sv
// -----------------------------------------------------------------------------
// wfm_loader
// Streams one complete waveform period into the DDS waveform table write port
// at addresses 0..DEPTH-1, checks that the stream length equals the table
// depth, and pulses done when the load ends (good or bad).
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-low
//   start      single-cycle request to arm a load (honoured only when idle)
//   abort      cancels a load in progress (no done pulse)
//   s          sample stream (slave side of wfm_loader_if)
//   wfm_wea    table write enable
//   wfm_waddr  table write address
//   wfm_din    table write data
//   busy       a load is in progress or just completing
//   done       one-cycle completion pulse
//   error      sticky length/abort error, cleared by the next accepted start
//   count      samples written in the current/last load
// -----------------------------------------------------------------------------
module wfm_loader #(
   parameter  int DEPTH = 1024,
   parameter  int OW    = 24,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   wfm_loader_if.slave     s,
   output logic            wfm_wea,
   output logic [AW-1:0]   wfm_waddr,
   output logic [OW-1:0]   wfm_din,
   output logic            busy,
   output logic            done,
   output logic            error,
   output logic [AW:0]     count
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH,
      DONE
   } state_t;

   localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

   state_t      state;
   logic [AW:0] addr;   // one extra bit so a full table (DEPTH) is representable
   logic        beat;

   assign beat  = s.s_valid & s.s_ready;

   // Every accepted write bumps addr, so it doubles as the written-sample count.
   assign count = addr;

   // NOTE: all state here is sequential and uses non-blocking assignments, so
   // every branch sees the values from the start of the cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         s.s_ready <= 1'b0;
         wfm_wea   <= 1'b0;
         wfm_waddr <= '0;
         wfm_din   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         addr      <= '0;
      end else begin
         // Pulses default low; address/data hold their last values.
         wfm_wea <= 1'b0;
         done    <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOAD;
                  s.s_ready <= 1'b1;
                  busy      <= 1'b1;
                  addr      <= '0;
                  error     <= 1'b0;
               end
            end

            LOAD: begin
               // Abort wins over a coincident beat: the sample is discarded.
               if (abort) begin
                  state     <= IDLE;
                  s.s_ready <= 1'b0;
                  busy      <= 1'b0;
                  error     <= 1'b1;
               end else if (beat) begin
                  wfm_wea   <= 1'b1;
                  wfm_waddr <= addr[AW-1:0];
                  wfm_din   <= s.s_data;
                  addr      <= addr + 1'b1;
                  if (s.s_last) begin
                     // Ending before the last table slot is a short load.
                     state     <= DONE;
                     s.s_ready <= 1'b0;
                     error     <= (addr != LAST_ADDR);
                  end else if (addr == LAST_ADDR) begin
                     // Table full but the period continues: swallow the rest.
                     state <= FLUSH;
                     error <= 1'b1;
                  end
               end
            end

            FLUSH: begin
               if (abort) begin
                  state     <= IDLE;
                  s.s_ready <= 1'b0;
                  busy      <= 1'b0;
               end else if (beat && s.s_last) begin
                  state     <= DONE;
                  s.s_ready <= 1'b0;
               end
            end

            DONE: begin
               // done is registered off this state, so it lands as busy drops.
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end

            default: begin
               state     <= IDLE;
               s.s_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule : wfm_loader
